// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, resolves PC+4/branch/jump successors and
// runs the instruction-memory req/ack handshake. Define PC_SEQ_TRAP_EN for misaligned-target traps.
module pc_sequencer #(
  parameter int unsigned      WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(64'h100)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  output logic             inst_valid,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             stall,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
`ifdef PC_SEQ_TRAP_EN
  output logic             trap,
`endif
  output logic             halted
);

`ifdef PC_SEQ_TRAP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_HALT, S_TRAP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_HALT
  } state_t;
`endif

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             halted_q, halted_d;
`ifdef PC_SEQ_TRAP_EN
  logic             trap_q, trap_d;
`endif

  logic             resolve;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_inc;

  // Sequential successor wraps modulo 2^WIDTH; the carry out is simply dropped.
  function automatic logic [WIDTH-1:0] pc_increment(input logic [WIDTH-1:0] cur);
    return cur + PC_STEP;
  endfunction

  function automatic logic [WIDTH-1:0] align_target(input logic [WIDTH-1:0] tgt);
    return tgt & ALIGN_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [WIDTH-1:0] tgt);
    return (tgt & ~ALIGN_MASK) != '0;
  endfunction

  assign pc_inc     = pc_increment(pc_q);
  assign next_pc    = pc_inc;
  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign inst_valid = imem_req & imem_ack;
  assign halted     = halted_q;
`ifdef PC_SEQ_TRAP_EN
  assign trap       = trap_q;
`endif

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    resolve = 1'b0;

    case (state_q)
      S_IDLE:          state_d = S_FETCH;
      S_FETCH, S_WAIT: begin
        if (imem_ack) resolve = 1'b1;
        else          state_d = S_WAIT;
      end
      S_HOLD:          resolve = ~stall;
      S_HALT:          state_d = S_HALT;
`ifdef PC_SEQ_TRAP_EN
      S_TRAP:          state_d = S_FETCH;
`endif
      default:         state_d = S_IDLE;
    endcase

    // Control inputs only matter at a commit or when a hold is released.
    if (resolve) begin
      if (halt) begin
        state_d = S_HALT;
      end else if (stall) begin
        state_d = S_HOLD;
      end else begin
        state_d = S_FETCH;
        if (redirect) begin
`ifdef PC_SEQ_TRAP_EN
          if (is_misaligned(target)) begin
            pc_d    = TRAP_VECTOR;
            state_d = S_TRAP;
          end else begin
            pc_d = target;
          end
`else
          pc_d = align_target(target);
`endif
        end else begin
          pc_d = pc_inc;
        end
      end
    end

    halted_d = (state_d == S_HALT);
`ifdef PC_SEQ_TRAP_EN
    trap_d   = (state_d == S_TRAP);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
`ifdef PC_SEQ_TRAP_EN
      trap_q   <= trap_d;
`endif
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the processor fetch path. It owns the PC register and generates the sequential PC+4 successor. It selects between sequential, branch and jump successors, and runs a request/acknowledge handshake with instruction memory so fetch can tolerate wait states, stalls and halts. It sits between the control unit (redirect, stall and halt requests) and the instruction memory port.

## Interface
- `WIDTH`, 64, PC and address width.
- `RESET_PC`, 0, PC value loaded on reset.
- `TRAP_VECTOR`, 64'h100, PC loaded on a misaligned-target trap (used only with `PC_SEQ_TRAP_EN`).

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  WIDTH  fetch address; always equals `pc`.
- `imem_ack`  in  1  memory has delivered the instruction for `imem_addr`.
- `inst_valid`  out  1  commit strobe: `imem_req & imem_ack`.
- `branch_taken`  in  1  take branch at commit.
- `branch_target`  in  WIDTH  branch destination.
- `jump`  in  1  take jump at commit.
- `jump_target`  in  WIDTH  jump destination.
- `stall`  in  1  hold PC at commit.
- `halt`  in  1  stop fetching permanently (until reset).
- `pc`  out  WIDTH  current PC (registered).
- `next_pc`  out  WIDTH  `pc + 4` (combinational).
- `halted`  out  1  registered; 1 in HALT.
- `trap`  out  1  registered one-cycle pulse; present only with `PC_SEQ_TRAP_EN`.

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALT, plus TRAP (with macro only).
- Reset values:
  - `pc=RESET_PC`, state IDLE.
  - `imem_req=0`, `inst_valid=0`, `halted=0`, `trap=0`.
- `imem_req` is 1 in FETCH and WAIT, and 0 in all other states.
- IDLE: always goes to FETCH next cycle. Any `imem_ack` in IDLE is ignored.
- FETCH/WAIT without ack: go to (or stay in) WAIT. `imem_addr` is held stable.
- Commit is the cycle where `imem_req & imem_ack`. Control inputs are sampled only at commit or in HOLD. Priority order:
  - `halt`: PC unchanged; go to HALT.
  - `stall`: PC unchanged; go to HOLD.
  - `jump`: `pc <= jump_target`.
  - `branch_taken`: `pc <= branch_target`.
  - otherwise: `pc <= pc + 4`.
  - In the last three cases, next state is FETCH.
- HOLD: `imem_req=0`. While `stall=1`, stay in HOLD. Once `stall=0`, apply the same priority list using the inputs of that cycle, then go to FETCH (or HALT).
- HALT: absorbing; only `reset` exits. `pc` is frozen.
- Arithmetic: `pc + 4` is modulo 2^WIDTH, so `2^WIDTH-4` becomes 0. No carry out.
- Alignment (no macro): the selected target has bits [1:0] forced to 0.
- Only the selected target is checked or masked; the unselected target is don't-care.
- `reset` dominates every state, including a pending WAIT. `imem_req` drops in the cycle after `reset` is sampled. A late `imem_ack` arriving afterwards is ignored.

## Timing
- `pc`, `halted`, `trap` and state are flops.
- `imem_req`, `imem_addr`, `inst_valid` and `next_pc` are decoded from flops (plus `imem_ack` for `inst_valid`).
- First request: the cycle after reset deasserts (IDLE takes one cycle).
- Zero-wait memory gives one commit per cycle; FETCH→FETCH has no bubble.
- N wait cycles give N+1 cycles per instruction.
- A redirect takes effect on `imem_addr` in the cycle after commit.
- A stall of S cycles, asserted at commit, inserts S cycles with `imem_req=0`.

## Configuration
- `PC_SEQ_TRAP_EN` defined:
  - A selected jump or branch target with bits [1:0] ≠ 0 causes `pc <= TRAP_VECTOR`.
  - `trap=1` for exactly one cycle, in state TRAP, with `imem_req=0`.
  - The state then goes to FETCH.
  - `halt` and `stall` still outrank the trap.
- `PC_SEQ_TRAP_EN` undefined: no TRAP state and no `trap` port; targets are masked as described in Operation.

## Test plan
- Reset, then `imem_ack` held at 1 → one idle cycle with `imem_req=0`, then `imem_addr` = 0, 4, 8, 12 on consecutive cycles, with `inst_valid` high each cycle.
- At `pc=0x10`, `imem_ack` delayed 3 cycles → `imem_req=1` and `imem_addr=0x10` for 4 cycles, a single `inst_valid` pulse, then `pc=0x14`.
- At commit, `jump=1` (`jump_target=0x200`) and `branch_taken=1` (`branch_target=0x300`) → `pc=0x200`; a separate commit with `branch_taken` only → `pc=0x300`.
- `stall=1` for 2 cycles at commit with `pc=0x8`; `branch_taken=1` with target 0x40 when `stall` drops → `imem_req=0` for 2 cycles, then `imem_addr=0x40`. Also assert `reset` mid-WAIT → next cycle `pc=RESET_PC` and `imem_req=0`.
- `RESET_PC=2^64-4` → first commit wraps to `pc=0`; `halt=1` at the next commit → `halted=1`, `imem_req=0` and `pc=0` held for 10+ cycles until reset.
- `jump_target=0x202` at commit → with the macro: `trap` pulses once and `pc=0x100`; without the macro: `pc=0x200`.
